// File: rtl/mha_pkg.sv
// Shared definitions for the QKV SRAM sequencer: FSM states, slot/block
// counts and the per-slot address helper used by the address generators.
package mha_pkg;

  // Q, K and V each contribute 16 slots to one SRAM row group.
  localparam int QKV_SLOTS = 48;
  localparam int PE_BLOCKS = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // Row address of slot `slot` within beat `beat`.
  function automatic int unsigned slot_addr(input int unsigned beat,
                                            input int unsigned slot);
    return beat * unsigned'(QKV_SLOTS) + slot;
  endfunction

endpackage

// File: rtl/qkv_addr_gen.sv
// Combinational expansion of a beat index into the packed 48-slot
// address bus (slot 0 in the LSBs).
module qkv_addr_gen
  import mha_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int B_WIDTH    = 3
) (
  input  logic [B_WIDTH-1:0]              beat,
  output logic [QKV_SLOTS*ADDR_WIDTH-1:0] addr_bus
);

  // One address per slot; the result is truncated to the SRAM address width.
  for (genvar gi = 0; gi < QKV_SLOTS; gi++) begin : g_slot
    assign addr_bus[gi*ADDR_WIDTH +: ADDR_WIDTH] =
      ADDR_WIDTH'(slot_addr(32'(beat), unsigned'(gi)));
  end

endmodule

// File: rtl/qkv_sram_seq.sv
// Sequencer in front of the multi-port QKV SRAM: writes BEATS PE beats,
// then replays them to the attention stage paced by rd_ready.
module qkv_sram_seq
  import mha_pkg::*;
#(
  parameter int ROW_COUNT  = 192,
  parameter int BIT_WIDTH  = 20,
  parameter int PARTITION1 = 16,
  parameter int ADDR_WIDTH = $clog2(ROW_COUNT),
  parameter int BEATS      = ROW_COUNT / 48
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [PE_BLOCKS*BIT_WIDTH*PARTITION1-1:0] in_data,
  input  logic                                   rd_ready,
  output logic                                   sram_we,
  output logic                                   sram_rd_en,
  output logic [QKV_SLOTS*ADDR_WIDTH-1:0]        sram_addr_qkv,
  output logic [QKV_SLOTS*ADDR_WIDTH-1:0]        sram_r_addr_qkv,
  output logic [PE_BLOCKS*BIT_WIDTH*PARTITION1-1:0] sram_din,
  output logic                                   rd_data_valid,
  output logic                                   busy,
  output logic                                   done
);

  localparam int DATA_WIDTH = PE_BLOCKS * BIT_WIDTH * PARTITION1;
  localparam int BUS_WIDTH  = QKV_SLOTS * ADDR_WIDTH;
  localparam int B_WIDTH    = $clog2(BEATS + 1);
  localparam logic [B_WIDTH-1:0] LAST_BEAT = B_WIDTH'(BEATS - 1);

  seq_state_e             state_q, state_d;
  logic [B_WIDTH-1:0]     b_q, b_d;
  logic                   we_q, we_d;
  logic                   rd_en_q, rd_en_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]  din_q, din_d;
  logic [BUS_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [BUS_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [BUS_WIDTH-1:0]   wr_bus, rd_bus;
  logic                   accept, issue;

  qkv_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .B_WIDTH(B_WIDTH)) u_wr_gen (
    .beat     (b_q),
    .addr_bus (wr_bus)
  );

  qkv_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .B_WIDTH(B_WIDTH)) u_rd_gen (
    .beat     (b_q),
    .addr_bus (rd_bus)
  );

  // Handshake and issue qualifiers decoded from the registered state.
  assign in_ready = (state_q == ST_WRITE);
  assign accept   = in_valid & in_ready;
  assign issue    = (state_q == ST_READ) & rd_ready;

  // Next-state, beat counter and registered SRAM-side signals.
  always_comb begin
    state_d    = state_q;
    b_d        = b_q;
    we_d       = accept;
    din_d      = accept ? in_data : din_q;
    wr_addr_d  = accept ? wr_bus : wr_addr_q;
    rd_en_d    = issue;
    rd_addr_d  = issue ? rd_bus : rd_addr_q;
    rd_valid_d = rd_en_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WRITE;
          b_d     = '0;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          if (b_q == LAST_BEAT) begin
            b_d     = '0;
            state_d = ST_READ;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      ST_READ: begin
        // b reaches BEATS for the DRAIN/DONE cycles only; it is cleared on the next start.
        if (issue) begin
          b_d = b_q + 1'b1;
          if (b_q == LAST_BEAT) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any pass in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      b_q        <= '0;
      we_q       <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      din_q      <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      we_q       <= we_d;
      rd_en_q    <= rd_en_d;
      rd_valid_q <= rd_valid_d;
      din_q      <= din_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign sram_we         = we_q;
  assign sram_rd_en      = rd_en_q;
  assign sram_din        = din_q;
  assign sram_addr_qkv   = wr_addr_q;
  assign sram_r_addr_qkv = rd_addr_q;
  assign rd_data_valid   = rd_valid_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);

endmodule

// File: tb/tb_qkv_sram_seq.sv
// Self-checking bench for qkv_sram_seq: table of passes with input
// patterns, a write/read scoreboard and a hand-written mid-pass reset.
module tb_qkv_sram_seq;
  import mha_pkg::*;

  localparam int ROW_COUNT  = 192;
  localparam int BIT_WIDTH  = 20;
  localparam int PARTITION1 = 16;
  localparam int AW    = $clog2(ROW_COUNT);
  localparam int BEATS = ROW_COUNT / 48;
  localparam int DW    = 12 * BIT_WIDTH * PARTITION1;
  localparam int BUSW  = 48 * AW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            rd_ready = 1'b0;
  logic            sram_we, sram_rd_en;
  logic [BUSW-1:0] sram_addr_qkv, sram_r_addr_qkv;
  logic [DW-1:0]   sram_din;
  logic            rd_data_valid, busy, done;

  always #5 clk = ~clk;

  qkv_sram_seq #(
    .ROW_COUNT(ROW_COUNT), .BIT_WIDTH(BIT_WIDTH), .PARTITION1(PARTITION1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .rd_ready(rd_ready),
    .sram_we(sram_we), .sram_rd_en(sram_rd_en),
    .sram_addr_qkv(sram_addr_qkv), .sram_r_addr_qkv(sram_r_addr_qkv),
    .sram_din(sram_din), .rd_data_valid(rd_data_valid),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [BUSW-1:0] addr;
    logic [DW-1:0]   din;
  } wr_exp_t;

  typedef struct {
    string      name;
    logic [7:0] vpat;      // in_valid per cycle after start, bit 0 first
    logic [7:0] rpat;      // rd_ready per cycle after start, bit 0 first
    bit         noise;     // assert start and in_valid during READ
    int         gap;       // idle cycles before start
    int         exp_busy;  // expected busy cycles for the pass
  } vec_t;

  wr_exp_t         wr_q[$];
  logic [BUSW-1:0] rd_q[$];
  wr_exp_t         mon_e;
  logic [BUSW-1:0] mon_r;
  logic [BUSW-1:0] last_rd_addr = '0;
  logic            have_last_rd = 1'b0;
  logic            exp_valid_next = 1'b0;
  int n_pass = 0, n_total = 0;
  int cnt_we = 0, cnt_rd = 0, cnt_valid = 0, cnt_done = 0, cnt_busy = 0;
  int m_state = 0;  // 0 idle, 1 write, 2 read, 3 drain, 4 done
  int m_b = 0;
  vec_t tbl[6];

  function automatic logic [BUSW-1:0] exp_bus(input int beat);
    logic [BUSW-1:0] bus;
    for (int s = 0; s < 48; s++) bus[s*AW +: AW] = AW'(beat * 48 + s);
    return bus;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_bus(input string name, input logic [BUSW-1:0] act, input logic [BUSW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got slot0=%0d slot47=%0d, expected slot0=%0d slot47=%0d",
                  name, act[AW-1:0], act[47*AW +: AW], exp[AW-1:0], exp[47*AW +: AW]);
  endtask

  // Scoreboard and per-cycle monitor, sampled away from the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (sram_we && sram_rd_en) chk("we_rd_overlap", 1, 0);
      chk("rd_data_valid", rd_data_valid, exp_valid_next);
      exp_valid_next = 1'b0;
      if (sram_we) begin
        cnt_we++;
        if (wr_q.size() == 0) chk("unexpected_we", 1, 0);
        else begin
          mon_e = wr_q.pop_front();
          chk_bus("wr_addr", sram_addr_qkv, mon_e.addr);
          n_total++;
          if (sram_din === mon_e.din) n_pass++;
          else $display("FAIL sram_din: got low %0h, expected low %0h",
                        sram_din[63:0], mon_e.din[63:0]);
        end
      end
      if (sram_rd_en) begin
        cnt_rd++;
        if (rd_q.size() == 0) chk("unexpected_rd_en", 1, 0);
        else begin
          mon_r = rd_q.pop_front();
          chk_bus("rd_addr", sram_r_addr_qkv, mon_r);
          last_rd_addr   = mon_r;
          have_last_rd   = 1'b1;
          exp_valid_next = 1'b1;
        end
      end else if (have_last_rd && busy) begin
        chk_bus("rd_addr_hold", sram_r_addr_qkv, last_rd_addr);
      end
      if (rd_data_valid) cnt_valid++;
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
  end

  // Drive one cycle, check the state decodes, and advance the reference model.
  task automatic step(input logic s, input logic v, input logic r);
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    start = s; in_valid = v; rd_ready = r; in_data = d;
    chk("in_ready", in_ready, m_state == 1);
    chk("busy", busy, m_state != 0);
    chk("done", done, m_state == 4);
    case (m_state)
      0: if (s) begin m_state = 1; m_b = 0; end
      1: if (v) begin
           wr_q.push_back('{addr: exp_bus(m_b), din: d});
           if (m_b == BEATS - 1) begin m_b = 0; m_state = 2; end
           else m_b++;
         end
      2: if (r) begin
           rd_q.push_back(exp_bus(m_b));
           if (m_b == BEATS - 1) m_state = 3;
           else m_b++;
         end
      3: m_state = 4;
      default: m_state = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input vec_t t);
    int  k;
    logic v, r, s;
    repeat (t.gap) step(1'b0, 1'b0, 1'b0);
    cnt_we = 0; cnt_rd = 0; cnt_valid = 0; cnt_done = 0; cnt_busy = 0;
    step(1'b1, 1'b0, 1'b0);
    k = 1;
    while (m_state != 0 && k < 100) begin
      s = t.noise && (m_state == 2);
      v = t.vpat[(k-1) % 8] | (t.noise && (m_state == 2 || m_state == 3));
      r = t.rpat[(k-1) % 8];
      step(s, v, r);
      k++;
    end
    $display("pass %s: we=%0d rd_en=%0d valid=%0d done=%0d busy_cycles=%0d",
             t.name, cnt_we, cnt_rd, cnt_valid, cnt_done, cnt_busy);
    chk({t.name, "_we_count"}, cnt_we, BEATS);
    chk({t.name, "_rd_count"}, cnt_rd, BEATS);
    chk({t.name, "_valid_count"}, cnt_valid, BEATS);
    chk({t.name, "_done_count"}, cnt_done, 1);
    chk({t.name, "_busy_cycles"}, cnt_busy, t.exp_busy);
    chk({t.name, "_wr_left"}, wr_q.size(), 0);
    chk({t.name, "_rd_left"}, rd_q.size(), 0);
  endtask

  initial begin
    tbl[0] = '{name: "nominal",   vpat: 8'hFF, rpat: 8'hFF, noise: 1'b0, gap: 0, exp_busy: 10};
    tbl[1] = '{name: "valid_gap", vpat: 8'h55, rpat: 8'hFF, noise: 1'b0, gap: 2, exp_busy: 13};
    tbl[2] = '{name: "ready_gap", vpat: 8'hFF, rpat: 8'h1F, noise: 1'b0, gap: 0, exp_busy: 13};
    tbl[3] = '{name: "noise",     vpat: 8'hFF, rpat: 8'hFF, noise: 1'b1, gap: 0, exp_busy: 10};
    tbl[4] = '{name: "mixed",     vpat: 8'hB3, rpat: 8'h6D, noise: 1'b0, gap: 0, exp_busy: 14};
    tbl[5] = '{name: "b2b",       vpat: 8'hFF, rpat: 8'hFF, noise: 1'b0, gap: 0, exp_busy: 10};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_rd_en", sram_rd_en, 0);
    chk("rst_valid", rd_data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_bus("rst_wr_addr", sram_addr_qkv, '0);
    chk_bus("rst_rd_addr", sram_r_addr_qkv, '0);
    chk("rst_din", sram_din == '0, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of WRITE after two accepted beats
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    start = 1'b0; in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("midrst_we", sram_we, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk_bus("midrst_wr_addr", sram_addr_qkv, '0);
    chk("midrst_din", sram_din == '0, 1);
    wr_q.delete();
    rd_q.delete();
    m_state = 0; m_b = 0;
    have_last_rd = 1'b0;
    exp_valid_next = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy_next", busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table of passes, each starting right after the previous one ends
    for (int i = 0; i < 6; i++) run_pass(tbl[i]);

    repeat (3) step(1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/qkv_sram_seq.md
# qkv_sram_seq

Sequencer that sits directly upstream of the multi-port QKV SRAM (`sram_multp_addr`). It accepts Q/K/V result beats from the 12 PE blocks over a valid/ready stream and registers them into the SRAM with 48 per-row write addresses. It then replays the stored rows to the attention stage with 48 per-row read addresses, paced by downstream ready. One pass is one write phase followed by one read phase, started by a single pulse.

## Interface
Parameters:
- `ROW_COUNT`, 192: SRAM depth in rows; must be a multiple of 48.
- `BIT_WIDTH`, 20: width of one PE element.
- `PARTITION1`, 16: elements per PE block per beat.
- `ADDR_WIDTH`, `$clog2(ROW_COUNT)`: SRAM address width.
- `BEATS`, `ROW_COUNT/48`: write beats (and read beats) per pass.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a pass from IDLE.
- `in_valid` in 1: PE beat valid.
- `in_ready` out 1: sequencer accepts a beat.
- `in_data` in 12*BIT_WIDTH*PARTITION1: PE blocks 0..11, block 0 in the LSBs.
- `rd_ready` in 1: downstream can take one read beat.
- `sram_we` out 1: to SRAM `we`.
- `sram_rd_en` out 1: to SRAM `rd_en`.
- `sram_addr_qkv` out 48*ADDR_WIDTH: write addresses, slot s=q*16+r, s=0 in the LSBs.
- `sram_r_addr_qkv` out 48*ADDR_WIDTH: read addresses, same slot order.
- `sram_din` out 12*BIT_WIDTH*PARTITION1: registered copy of the accepted `in_data`.
- `rd_data_valid` out 1: SRAM `dout` is valid this cycle.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse at end of pass.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
  - IDLE: `start` moves to WRITE and clears the beat counter `b`. `start` is ignored in every other state.
  - WRITE: `in_ready`=1.
    - On `in_valid`&`in_ready`: register `in_data` into `sram_din` and assert `sram_we` for the next cycle.
    - Write address for slot s is b*48+s. Then b++.
    - After beat BEATS-1 is accepted: clear b and go to READ.
  - READ: `in_ready`=0.
    - Each cycle with `rd_ready`=1: `sram_rd_en`=1 next cycle and `sram_r_addr_qkv` slot s = b*48+s. Then b++.
    - After issuing beat BEATS-1: go to DRAIN.
    - With `rd_ready`=0: `sram_rd_en`=0 and addresses hold.
  - DRAIN: one cycle so the last read data emerges, then go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Address arithmetic: b*48+s is computed in ADDR_WIDTH bits; it never exceeds ROW_COUNT-1 by construction. `b` is $clog2(BEATS+1) bits wide and saturates at BEATS only transiently.
- `sram_we` and `sram_rd_en` are never both 1 in the same cycle.
- `in_valid` outside WRITE is ignored and never accepted. `in_data` is not consumed.
- `rd_ready` outside READ is ignored.
- Reset mid-pass drops all progress: state IDLE, b=0. SRAM contents are undefined to the consumer.

## Timing
- Reset values: `in_ready`, `sram_we`, `sram_rd_en`, `rd_data_valid`, `busy`, `done` all 0. Address and `sram_din` buses all 0.
- `in_ready` is a registered state decode: it rises the cycle after `start`.
- Write latency: a beat accepted at edge N drives `sram_we`/`sram_din`/`sram_addr_qkv` during cycle N+1. The SRAM stores it at edge N+2.
- Read latency: `rd_ready` sampled at edge N drives `sram_rd_en`/`sram_r_addr_qkv` during cycle N+1. SRAM `dout` is valid and `rd_data_valid`=1 during cycle N+2.
- `rd_data_valid` is `sram_rd_en` delayed one cycle.
- The consumer must take every beat flagged by `rd_data_valid`; there is no backpressure on data, only on issue.
- Throughput is one beat per cycle in both phases.
- Minimum pass length: 1 (start) + BEATS + BEATS + 1 (DRAIN) + 1 (DONE) cycles.
- `busy` is 1 from the cycle after `start` through the DONE cycle inclusive.

## Structure
- Shared package `mha_pkg`:
  - FSM state enum.
  - Constant QKV_SLOTS=48 (3 x 16).
  - PE_BLOCKS=12.
  - Address-pack helper for the 48-slot bus.
- One sub-module, `qkv_addr_gen`: combinational, takes beat index → 48-slot packed address bus. It is instantiated twice, once for the write bus and once for the read bus.

## Test plan
- Reset mid-WRITE after 2 beats → all outputs 0 and `busy`=0 next cycle. A new `start` restarts at b=0, first write address slot 0 = 0.
- Nominal pass with BEATS=4, `in_valid` held high, `rd_ready` high:
  - `sram_we` high for 4 consecutive cycles; slot 47 addresses 47, 95, 143, 191.
  - `rd_data_valid` high for 4 cycles; `done` pulses exactly once.
- Gaps: `in_valid` toggling 1,0,1,0 → exactly 4 `sram_we` pulses, `sram_din` equal to each accepted beat.
- `rd_ready` low for 3 cycles mid-READ → `sram_rd_en` 0 and `sram_r_addr_qkv` held. Resumes at the next beat with no skipped or duplicated addresses.
- `start` asserted during READ and `in_valid` during READ → both ignored, no extra writes, pass completes unchanged.
- Back-to-back passes: `start` in the cycle after `done` → second pass write addresses restart at 0 and `sram_we`/`sram_rd_en` never overlap.
